// File: rtl/pulse_train_gen.sv
// Configurable pulse-train generator: emits N (or endless) pulses of a latched period/high time.
// Config is latched and clamped on start; every output comes straight from a flop.
module pulse_train_gen #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] high_cycles,
  input  logic [COUNT_W-1:0]  pulse_count,
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  pulses_sent
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;

  state_t              state_reg, state_next;
  logic [PERIOD_W-1:0] per_reg, per_next;
  logic [PERIOD_W-1:0] high_reg, high_next;
  logic [PERIOD_W-1:0] phase_reg, phase_next;
  logic [COUNT_W-1:0]  cnt_reg, cnt_next;
  logic [COUNT_W-1:0]  sent_reg, sent_next;
  logic                pulse_reg, pulse_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic [PERIOD_W-1:0] per_clamped, high_clamped, low_len;
  logic                start_req, high_end, low_end, last_pulse, latch;

  // P >= 2 and 1 <= H <= P-1 guarantee both phases last at least one cycle.
  assign per_clamped = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;

  always_comb begin
    high_clamped = (high_cycles == '0) ? PERIOD_W'(1) : high_cycles;
    if (high_clamped > per_clamped - PERIOD_W'(1))
      high_clamped = per_clamped - PERIOD_W'(1);
  end

  assign low_len    = per_reg - high_reg;
  assign start_req  = start & ~stop;
  assign high_end   = (phase_reg == high_reg);
  assign low_end    = (phase_reg == low_len);
  assign last_pulse = (cnt_reg != '0) && (sent_reg == cnt_reg);
  assign latch      = (state_reg == IDLE) && start_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      per_reg   <= '0;
      high_reg  <= '0;
      cnt_reg   <= '0;
      phase_reg <= '0;
      sent_reg  <= '0;
      pulse_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      per_reg   <= per_next;
      high_reg  <= high_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      sent_reg  <= sent_next;
      pulse_reg <= pulse_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_req) state_next = HIGH;
      HIGH: begin
        if (stop)          state_next = FINISH;
        else if (high_end) state_next = LOW;
      end
      LOW: begin
        if (stop)         state_next = FINISH;
        else if (low_end) state_next = last_pulse ? FINISH : HIGH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops on the same edge.
  always_comb begin
    per_next   = per_reg;
    high_next  = high_reg;
    cnt_next   = cnt_reg;
    sent_next  = sent_reg;
    phase_next = '0;
    pulse_next = (state_next == HIGH);
    busy_next  = (state_next == HIGH) || (state_next == LOW);
    done_next  = (state_next == FINISH);

    if (state_next == HIGH || state_next == LOW)
      phase_next = (state_next != state_reg) ? PERIOD_W'(1) : phase_reg + PERIOD_W'(1);

    if (latch) begin
      per_next  = per_clamped;
      high_next = high_clamped;
      cnt_next  = pulse_count;
      sent_next = COUNT_W'(1);
    end else if (state_reg == LOW && state_next == HIGH) begin
      sent_next = sent_reg + COUNT_W'(1);
    end
  end

  assign pulse_out   = pulse_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign pulses_sent = sent_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: measures pulse widths, spacing and strobes against hand values.
module tb_pulse_train_gen;

  logic        clk, rst_n, start, stop;
  logic [15:0] period, high_cycles;
  logic [7:0]  pulse_count;
  logic        pulse_out, busy, done;
  logic [7:0]  pulses_sent;

  int checks   = 0;
  int failures = 0;

  int rises, hmin, hmax, smin, smax, dones, busy_done;

  pulse_train_gen #(.PERIOD_W(16), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .period(period), .high_cycles(high_cycles), .pulse_count(pulse_count),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Issues a one-cycle start, then scrambles config to prove it was latched.
  task automatic do_start(input logic [15:0] p, input logic [15:0] h, input logic [7:0] c);
    @(negedge clk);
    period = p; high_cycles = h; pulse_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    period = 16'($urandom); high_cycles = 16'($urandom); pulse_count = 8'($urandom);
  endtask

  // Samples each negedge from the first high cycle until three cycles past done.
  task automatic run_train(input int max_cycles, input int poke_at,
                           output int r, output int h_lo, output int h_hi,
                           output int s_lo, output int s_hi, output int d, output int bd);
    logic prev;
    int   hrun, last_rise, post;
    bit   seen;
    prev = 1'b0; hrun = 0; last_rise = -1; post = 0; seen = 1'b0;
    r = 0; h_lo = 1 << 30; h_hi = 0; s_lo = 1 << 30; s_hi = 0; d = 0; bd = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (pulse_out && !prev) begin
        r++;
        if (last_rise >= 0) begin
          if (c - last_rise < s_lo) s_lo = c - last_rise;
          if (c - last_rise > s_hi) s_hi = c - last_rise;
        end
        last_rise = c;
        hrun = 0;
      end
      if (pulse_out) hrun++;
      if (!pulse_out && prev) begin
        if (hrun < h_lo) h_lo = hrun;
        if (hrun > h_hi) h_hi = hrun;
      end
      if (done) begin
        d++;
        seen = 1'b1;
        if (busy) bd = 1;
      end
      prev = pulse_out;
      if (c == poke_at) start = 1'b1;
      else if (c == poke_at + 1) start = 1'b0;
      if (seen) begin
        if (post == 3) break;
        post++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    period = '0; high_cycles = '0; pulse_count = '0;
    #12;
    check("rst_pulse_out", 32'(pulse_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sent", 32'(pulses_sent), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8 pulses, 5 high, 400 period
    do_start(16'd400, 16'd5, 8'd8);
    check("t1_first_pulse", 32'(pulse_out), 1);
    check("t1_first_busy", 32'(busy), 1);
    check("t1_first_sent", 32'(pulses_sent), 1);
    run_train(4000, -1, rises, hmin, hmax, smin, smax, dones, busy_done);
    check("t1_rises", 32'(rises), 8);
    check("t1_high_min", 32'(hmin), 5);
    check("t1_high_max", 32'(hmax), 5);
    check("t1_space_min", 32'(smin), 400);
    check("t1_space_max", 32'(smax), 400);
    check("t1_dones", 32'(dones), 1);
    check("t1_busy_at_done", 32'(busy_done), 0);
    check("t1_sent_end", 32'(pulses_sent), 8);
    check("t1_busy_end", 32'(busy), 0);

    // clamped to P=2, H=1
    do_start(16'd1, 16'd0, 8'd3);
    run_train(100, -1, rises, hmin, hmax, smin, smax, dones, busy_done);
    check("t2_rises", 32'(rises), 3);
    check("t2_high", 32'(hmax), 1);
    check("t2_high_min", 32'(hmin), 1);
    check("t2_space", 32'(smax), 2);
    check("t2_dones", 32'(dones), 1);
    check("t2_sent_end", 32'(pulses_sent), 3);

    // H clamped to 9; start re-pulsed mid-train
    do_start(16'd10, 16'd20, 8'd2);
    run_train(200, 5, rises, hmin, hmax, smin, smax, dones, busy_done);
    check("t3_rises", 32'(rises), 2);
    check("t3_high_min", 32'(hmin), 9);
    check("t3_high_max", 32'(hmax), 9);
    check("t3_space", 32'(smin), 10);
    check("t3_dones", 32'(dones), 1);
    check("t3_sent_end", 32'(pulses_sent), 2);

    // start+stop together in IDLE, then stop alone in IDLE
    @(negedge clk);
    period = 16'd10; high_cycles = 16'd3; pulse_count = 8'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t4_both_busy", 32'(busy), 0);
    check("t4_both_done", 32'(done), 0);
    check("t4_both_pulse", 32'(pulse_out), 0);
    check("t4_both_sent", 32'(pulses_sent), 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_idle_done", 32'(done), 0);
    check("t4_stop_idle_busy", 32'(busy), 0);

    // start held during the FINISH cycle must be ignored
    do_start(16'd2, 16'd1, 8'd1);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("t5_done_seen", 32'(done), 1);
    period = 16'd2; high_cycles = 16'd1; pulse_count = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_finish_start_busy", 32'(busy), 0);
    check("t5_finish_start_pulse", 32'(pulse_out), 0);
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 0);

    // continuous train, stop in the 4th HIGH
    do_start(16'd50, 16'd10, 8'd0);
    for (int i = 0; i < 1000 && !(pulses_sent == 8'd4 && pulse_out); i++) @(negedge clk);
    check("t6_reach_4th_high", 32'(pulse_out && pulses_sent == 8'd4), 1);
    @(negedge clk);
    @(negedge clk);
    check("t6_still_high", 32'(pulse_out), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t6_stop_pulse", 32'(pulse_out), 0);
    check("t6_stop_done", 32'(done), 1);
    check("t6_stop_busy", 32'(busy), 0);
    check("t6_stop_sent", 32'(pulses_sent), 4);
    @(negedge clk);
    check("t6_done_once", 32'(done), 0);
    check("t6_sent_held", 32'(pulses_sent), 4);

    // reset during LOW of pulse 3, then start on the first edge after release
    do_start(16'd20, 16'd5, 8'd6);
    for (int i = 0; i < 200 && !(pulses_sent == 8'd3 && !pulse_out && busy); i++) @(negedge clk);
    check("t7_reach_low3", 32'(pulses_sent == 8'd3 && !pulse_out && busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_pulse", 32'(pulse_out), 0);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_sent", 32'(pulses_sent), 0);
    check("t7_rst_done", 32'(done), 0);
    @(negedge clk);
    period = 16'd20; high_cycles = 16'd5; pulse_count = 8'd6;
    start = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t7_restart_busy", 32'(busy), 1);
    check("t7_restart_sent", 32'(pulses_sent), 1);
    check("t7_restart_done", 32'(done), 0);
    run_train(400, -1, rises, hmin, hmax, smin, smax, dones, busy_done);
    check("t7_rises", 32'(rises), 6);
    check("t7_high", 32'(hmax), 5);
    check("t7_space", 32'(smin), 20);
    check("t7_dones", 32'(dones), 1);
    check("t7_sent_end", 32'(pulses_sent), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
